priority_encoder_stage: RTL

PRIORITY_ENCODER_STAGE -- requirements
Module: priority_encoder_stage

---
 rtl/priority_encoder_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/priority_encoder_stage.sv
// Debounced 8-button priority encoder feeding a one-entry output register.
// Raw levels are synchronized, debounced, edge-detected and the highest new press is encoded.
module priority_encoder_stage #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] btn,
    input  logic       clr,
    input  logic       ready,
    output logic [2:0] code,
    output logic       valid,
    output logic       multi,
    output logic       overflow
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    logic [7:0] sync1, sync2;
    logic [7:0] deb, prev;
    cnt_t       cnt [8];

    logic [7:0] press;
    logic       cand_any;
    logic [2:0] cand_code;
    logic       cand_multi;

    state_t     state, state_n;
    logic [2:0] code_n;
    logic       multi_n;
    logic       overflow_n;
    logic       drop;

    // NOTE: state is written with <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // NOTE: the counter array is only eight small registers, so it is reset like any other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb  <= '0;
            prev <= '0;
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
        end else begin
            prev <= deb;
            for (int i = 0; i < 8; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + cnt_t'(1);
                end
            end
        end
    end

    // Ascending scan so the highest pressed index wins.
    always_comb begin
        press      = deb & ~prev;
        cand_any   = |press;
        cand_multi = (press & (press - 8'd1)) != 8'd0;
        cand_code  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (press[i]) cand_code = 3'(i);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        code_n  = code;
        multi_n = multi;
        drop    = 1'b0;
        case (state)
            EMPTY: begin
                if (cand_any) begin
                    code_n  = cand_code;
                    multi_n = cand_multi;
                    state_n = FULL;
                end
            end
            FULL: begin
                if (ready) begin
                    if (cand_any) begin
                        code_n  = cand_code;
                        multi_n = cand_multi;
                    end else begin
                        state_n = EMPTY;
                    end
                end else if (cand_any) begin
                    drop = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
        overflow_n = drop | (overflow & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            code     <= 3'b000;
            multi    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            code     <= code_n;
            multi    <= multi_n;
            overflow <= overflow_n;
        end
    end

    assign valid = (state == FULL);

endmodule
